// File: rtl/play_sequencer_if.sv
// Signal bundle between the play-mode controller and the note sequencer.
// The master side drives session control and player/user events; the slave side is the sequencer.
interface play_sequencer_if #(
  parameter int unsigned SONG_CNT_BITS = 8,
  parameter int unsigned CLOCK_BITS    = 32
);
  logic                     en;
  logic                     start;
  logic [SONG_CNT_BITS-1:0] track;
  logic [CLOCK_BITS-1:0]    system_clock;
  logic                     snd_over;
  logic                     hit;
  logic [SONG_CNT_BITS-1:0] cnt;
  logic [CLOCK_BITS-1:0]    goal_clock;
  logic                     snd_start;
  logic                     can_hit;
  logic                     hit_taken;
  logic                     commit;
  logic                     miss;
  logic                     timeout;
  logic                     busy;
  logic                     done;

  modport master (
    output en, start, track, system_clock, snd_over, hit,
    input  cnt, goal_clock, snd_start, can_hit, hit_taken, commit, miss, timeout, busy, done
  );

  modport slave (
    input  en, start, track, system_clock, snd_over, hit,
    output cnt, goal_clock, snd_start, can_hit, hit_taken, commit, miss, timeout, busy, done
  );
endinterface

// File: rtl/play_sequencer.sv
// Play-mode note sequencer: steps the note index, launches each note, runs the hit window and
// emits exactly one score commit per note before reporting the session done.
module play_sequencer #(
  parameter int unsigned SONG_CNT_BITS  = 8,
  parameter int unsigned CLOCK_BITS     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned TO_BITS        = 28
) (
  input logic             clk,
  input logic             rst_n,
  play_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StLaunch, StWait, StCommit, StDone} state_e;

  localparam logic [TO_BITS-1:0]       ToLast = TO_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_BITS-1:0]       ToOne  = TO_BITS'(1);
  localparam logic [SONG_CNT_BITS-1:0] CntOne = SONG_CNT_BITS'(1);

  state_e                   state_q, state_d;
  logic [SONG_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [SONG_CNT_BITS-1:0] trk_q, trk_d;
  logic [CLOCK_BITS-1:0]    goal_q, goal_d;
  logic [TO_BITS-1:0]       to_cnt_q, to_cnt_d;
  logic                     can_hit_q, can_hit_d;
  logic                     hit_taken_q, hit_taken_d;
  logic                     to_flag_q, to_flag_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trk_d       = trk_q;
    goal_d      = goal_q;
    to_cnt_d    = to_cnt_q;
    can_hit_d   = can_hit_q;
    hit_taken_d = hit_taken_q;
    to_flag_d   = to_flag_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start && bus.en) begin
          trk_d   = bus.track;
          cnt_d   = '0;
          state_d = (bus.track == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        hit_taken_d = 1'b0;
        state_d     = StLaunch;
      end
      StLaunch: begin
        goal_d    = bus.system_clock;
        to_cnt_d  = '0;
        can_hit_d = 1'b1;
        to_flag_d = 1'b0;
        state_d   = StWait;
      end
      StWait: begin
        to_cnt_d = to_cnt_q + ToOne;
        // Only the first hit of a note is accepted; the window then closes.
        if (bus.hit && can_hit_q && !hit_taken_q) begin
          hit_taken_d = 1'b1;
          can_hit_d   = 1'b0;
        end
        if (bus.snd_over) begin
          can_hit_d = 1'b0;
          state_d   = StCommit;
        end else if (to_cnt_q == ToLast) begin
          can_hit_d = 1'b0;
          to_flag_d = 1'b1;
          state_d   = StCommit;
        end
      end
      StCommit: begin
        if (cnt_q == trk_q - CntOne) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + CntOne;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // en low behaves exactly like reset so a mid-session drop aborts without a commit.
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.en) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      trk_q       <= '0;
      goal_q      <= '0;
      to_cnt_q    <= '0;
      can_hit_q   <= 1'b0;
      hit_taken_q <= 1'b0;
      to_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trk_q       <= trk_d;
      goal_q      <= goal_d;
      to_cnt_q    <= to_cnt_d;
      can_hit_q   <= can_hit_d;
      hit_taken_q <= hit_taken_d;
      to_flag_q   <= to_flag_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.goal_clock = goal_q;
  assign bus.snd_start  = (state_q == StLaunch);
  assign bus.can_hit    = can_hit_q;
  assign bus.hit_taken  = hit_taken_q;
  assign bus.commit     = (state_q == StCommit);
  assign bus.miss       = (state_q == StCommit) && !hit_taken_q;
  assign bus.timeout    = (state_q == StCommit) && to_flag_q;
  assign bus.busy       = (state_q != StIdle) && (state_q != StDone);
  assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_play_sequencer.sv
// Randomised scoreboard bench for play_sequencer: a note-level timing model predicts every commit
// (index, miss, timeout, goal timestamp and cycle) and a monitor checks each commit as it appears.
module tb_play_sequencer;

  localparam int unsigned T = 20;

  typedef struct {
    int          idx;
    bit          miss;
    bit          to;
    logic [31:0] goal;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  play_sequencer_if #(.SONG_CNT_BITS(8), .CLOCK_BITS(32)) bus ();

  play_sequencer #(
    .SONG_CNT_BITS (8),
    .CLOCK_BITS    (32),
    .TIMEOUT_CYCLES(T),
    .TO_BITS       (28)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    bus.system_clock = 32'hA5A5_0000;
    forever begin
      @(posedge clk);
      #1;
      bus.system_clock = bus.system_clock + 32'd13;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 50000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every commit must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (bus.commit) begin
      if (sb_q.size() == 0) begin
        check("unexpected_commit", 64'(bus.commit), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("commit_cnt", 64'(bus.cnt), 64'(e.idx));
        check("commit_miss", 64'(bus.miss), 64'(e.miss));
        check("commit_timeout", 64'(bus.timeout), 64'(e.to));
        check("commit_hit_taken", 64'(bus.hit_taken), 64'(!e.miss));
        check("commit_goal", 64'(bus.goal_clock), 64'(e.goal));
        check("commit_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // mode: 0 random, 1 snd_over@10 hit@3, 2 no hits, 3 hits @2,@4, 4 hit with snd_over plus hits
  // in COMMIT/LOAD, 5 timeout. abort drops en during the WAIT of note 1.
  task automatic run_session(input int trk, input int mode, input bit abort);
    int          s, l, d, m, first_hit, exp_l;
    bit          seen, aborted;
    bit          hits[0:31];
    logic [31:0] goal;
    aborted = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.track = 8'(trk);
    s = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.track = 8'($urandom);
    if (trk == 0) begin
      @(negedge clk);
      check("empty_done", 64'(bus.done), 64'd1);
      check("empty_busy", 64'(bus.busy), 64'd0);
      check("empty_snd_start", 64'(bus.snd_start), 64'd0);
      return;
    end
    exp_l = s + 2;
    for (int k = 0; k < trk; k++) begin
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        @(negedge clk);
        if (bus.snd_start) seen = 1'b1;
      end
      if (!seen) begin
        check("snd_start_missing", 64'(bus.snd_start), 64'd1);
        return;
      end
      l    = cyc;
      goal = bus.system_clock;
      check("launch_cycle", 64'(l), 64'(exp_l));
      for (int o = 0; o < 32; o++) hits[o] = 1'b0;
      case (mode)
        1: begin d = 10; hits[3] = 1'b1; end
        2: d = int'($urandom_range(1, 12));
        3: begin d = 8; hits[2] = 1'b1; hits[4] = 1'b1; end
        4: begin d = 6; hits[6] = 1'b1; hits[7] = 1'b1; hits[8] = 1'b1; end
        5: d = T + 5;
        default: begin
          d = int'($urandom_range(1, T + 4));
          for (int o = 1; o < 32; o++) hits[o] = ($urandom_range(0, 4) == 0);
        end
      endcase
      if (abort && k == 1) begin
        d = 10;
        for (int o = 0; o < 32; o++) hits[o] = 1'b0;
      end
      m = (d > int'(T)) ? int'(T) : d;
      first_hit = 0;
      for (int o = 1; o <= m; o++) if (hits[o] && first_hit == 0) first_hit = o;
      if (!(abort && k == 1)) sb_q.push_back('{k, first_hit == 0, d > int'(T), goal, l + m + 1});
      for (int o = 1; o <= m + 2; o++) begin
        @(posedge clk);
        #1;
        bus.hit      = hits[o];
        bus.snd_over = (o == d);
        bus.start    = (mode == 0) && (o == 1) && ($urandom_range(0, 3) == 0);
        bus.track    = 8'($urandom);
        if (abort && k == 1 && o == 2) bus.en = 1'b0;
        @(negedge clk);
        if (abort && k == 1 && o == 3) begin
          check("abort_busy", 64'(bus.busy), 64'd0);
          check("abort_cnt", 64'(bus.cnt), 64'd0);
          check("abort_can_hit", 64'(bus.can_hit), 64'd0);
          aborted = 1'b1;
          break;
        end
        check("can_hit", 64'(bus.can_hit),
              64'((o <= m) && (first_hit == 0 || o <= first_hit)));
      end
      if (aborted) break;
      exp_l = l + m + 3;
    end
    if (!aborted) begin
      check("final_done", 64'(bus.done), 64'd1);
      check("final_busy", 64'(bus.busy), 64'd0);
      check("final_cnt", 64'(bus.cnt), 64'(trk - 1));
    end
    @(posedge clk);
    #1;
    bus.en       = 1'b1;
    bus.hit      = 1'b0;
    bus.snd_over = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, 64'(bus.cnt), 64'd0);
    check({tag, "_goal"}, 64'(bus.goal_clock), 64'd0);
    check({tag, "_flags"}, 64'({bus.snd_start, bus.can_hit, bus.hit_taken, bus.commit,
                                bus.miss, bus.timeout, bus.busy, bus.done}), 64'd0);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.start    = 1'b0;
    bus.track    = 8'd0;
    bus.snd_over = 1'b0;
    bus.hit      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // start with en low must be ignored
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.track = 8'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_no_en_busy", 64'(bus.busy), 64'd0);
    bus.en = 1'b1;

    run_session(3, 1, 1'b0);
    run_session(2, 2, 1'b0);
    run_session(1, 3, 1'b0);
    run_session(2, 4, 1'b0);
    run_session(1, 5, 1'b0);
    run_session(3, 0, 1'b1);
    run_session(0, 0, 1'b0);

    // reset while in DONE clears everything, including the last goal timestamp
    @(negedge clk);
    check("pre_reset_done", 64'(bus.done), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("done_reset");

    for (int i = 0; i < 30; i++) run_session(int'($urandom_range(0, 5)), 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
